keccak_host_ctrl: RTL

KECCAK_HOST_CTRL -- requirements
Module: keccak_host_ctrl

---
 rtl/keccak_host_ctrl.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/keccak_host_ctrl.sv
// Host-side sequencer for a Keccak core: accepts a hash command, streams message words
// into the core with block/last tracking, and buffers digest words in a 16-entry FIFO.
module keccak_host_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_start,
    input  logic [2:0]  cmd_mode,
    input  logic [7:0]  cmd_len_words,
    input  logic [10:0] cmd_d,
    output logic        cmd_ready,
    input  logic [63:0] msg_data,
    input  logic        msg_valid,
    output logic        msg_ready,
    output logic        core_start,
    output logic [63:0] core_dt_i,
    output logic [2:0]  core_cmode,
    output logic        core_last_block,
    output logic [10:0] core_d,
    input  logic        core_valid,
    input  logic        core_ready,
    input  logic        core_finish_hash,
    input  logic [31:0] core_dt_o_hash,
    output logic [31:0] dig_data,
    output logic        dig_valid,
    output logic        dig_last,
    input  logic        dig_ready,
    output logic        err_underrun,
    output logic        err_overflow,
    output logic        err_cmd
);
    localparam int FIFO_DEPTH = 16;

    typedef enum logic [2:0] {IDLE, START, FEED, WAIT_HASH, DRAIN} state_t;

    state_t      state;
    logic [2:0]  mode_q;
    logic [10:0] d_q;
    logic [7:0]  remaining;
    logic [4:0]  blk_cnt;
    logic        final_blk;

    logic [32:0] fifo_mem [FIFO_DEPTH];
    logic [3:0]  wr_ptr;
    logic [3:0]  rd_ptr;
    logic [4:0]  count;

    function automatic logic [4:0] rate_words(input logic [2:0] mode);
        logic [4:0] r;
        case (mode)
            3'd0:    r = 5'd18;
            3'd1:    r = 5'd17;
            3'd2:    r = 5'd13;
            3'd3:    r = 5'd9;
            3'd4:    r = 5'd21;
            default: r = 5'd17;
        endcase
        return r;
    endfunction

    logic [4:0] rate;
    logic       cmd_ok;
    logic       xfer;
    logic       in_final;
    logic       fifo_full;
    logic       fifo_empty;
    logic       pop;
    logic       wr_req;
    logic       wr_en;

    assign rate     = rate_words(mode_q);
    assign cmd_ok   = (cmd_mode <= 3'd5) && (cmd_len_words != 8'd0);
    assign xfer     = (state == FEED) && core_valid;
    // The final block is decided only at a block boundary; mid-block the latched flag holds.
    assign in_final = final_blk || ((blk_cnt == 5'd0) && (remaining <= {3'b000, rate}));

    assign fifo_full  = (count == 5'(FIFO_DEPTH));
    assign fifo_empty = (count == 5'd0);
    assign pop        = !fifo_empty && dig_ready;
    assign wr_req     = (state == WAIT_HASH) && core_ready;
    assign wr_en      = wr_req && (!fifo_full || pop);

    assign msg_ready       = xfer;
    assign core_dt_i       = (xfer && msg_valid) ? msg_data : 64'd0;
    assign core_last_block = (state == FEED) && in_final;
    assign core_cmode      = mode_q;
    assign core_d          = d_q;
    assign dig_valid       = !fifo_empty;
    assign dig_data        = fifo_empty ? 32'd0 : fifo_mem[rd_ptr][31:0];
    assign dig_last        = !fifo_empty && fifo_mem[rd_ptr][32];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cmd_ready    <= 1'b1;
            core_start   <= 1'b0;
            mode_q       <= 3'd0;
            d_q          <= 11'd0;
            remaining    <= 8'd0;
            blk_cnt      <= 5'd0;
            final_blk    <= 1'b0;
            err_underrun <= 1'b0;
            err_overflow <= 1'b0;
            err_cmd      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_start) begin
                        if (cmd_ok) begin
                            state        <= START;
                            cmd_ready    <= 1'b0;
                            core_start   <= 1'b1;
                            mode_q       <= cmd_mode;
                            d_q          <= cmd_d;
                            remaining    <= cmd_len_words;
                            blk_cnt      <= 5'd0;
                            final_blk    <= 1'b0;
                            err_underrun <= 1'b0;
                            err_overflow <= 1'b0;
                            err_cmd      <= 1'b0;
                        end else begin
                            err_cmd <= 1'b1;
                        end
                    end
                end
                START: begin
                    state      <= FEED;
                    core_start <= 1'b0;
                end
                FEED: begin
                    // The core is never stalled: a missing message word is sent as zero.
                    if (xfer) begin
                        remaining <= remaining - 8'd1;
                        final_blk <= in_final;
                        blk_cnt   <= (blk_cnt == rate - 5'd1) ? 5'd0 : blk_cnt + 5'd1;
                        if (!msg_valid) begin
                            err_underrun <= 1'b1;
                        end
                        if (remaining == 8'd1) begin
                            state <= WAIT_HASH;
                        end
                    end
                end
                WAIT_HASH: begin
                    if (core_ready && core_finish_hash) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (fifo_empty) begin
                        state     <= IDLE;
                        cmd_ready <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    cmd_ready  <= 1'b1;
                    core_start <= 1'b0;
                end
            endcase
            if (wr_req && fifo_full && !pop) begin
                err_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= 4'd0;
            rd_ptr <= 4'd0;
            count  <= 5'd0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 4'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 4'd1;
            end
            case ({wr_en, pop})
                2'b10:   count <= count + 5'd1;
                2'b01:   count <= count - 5'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            fifo_mem[wr_ptr] <= {core_finish_hash, core_dt_o_hash};
        end
    end

endmodule
